t_clk_flop: RTL and testbench

T_CLK_FLOP -- requirements
Module: t_clk_flop

---
 rtl/t_clk_flop.sv | 96 +++++++++
 tb/tb_t_clk_flop.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_clk_flop.sv
// ---------------------------------------------------------------------------
// t_clk_flop
//
// Purpose:
//   This block registers input `a` in the clk domain and produces `q`.
//   It then resamples `q` into the asynchronous clk2 domain to produce `q2`.
//   A free-running counter `cnt2` counts clk2 cycles.
//   All state is cleared as soon as reset_l falls, without waiting for a clock.
//
// Configuration:
//   T_CLK_FLOP_SYNC2_EN
//     When defined, q passes through two clk2 flops before reaching q2.
//     When undefined (the default build), a single clk2 flop is used.
//
// Parameters:
//   WIDTH    data width of a, q and q2
//   CNT_W    width of the clk2 cycle counter cnt2
//
// Ports:
//   clk      in   1       primary clock; the q path updates on posedge
//   reset_l  in   1       asynchronous active-low reset for both domains
//   clk2     in   1       secondary (fast) clock, asynchronous to clk
//   a        in   WIDTH   data sampled in the clk domain
//   q        out  WIDTH   a delayed by one clk cycle
//   q2       out  WIDTH   q resampled into the clk2 domain
//   cnt2     out  CNT_W   free-running clk2 cycle counter, wraps to 0
// ---------------------------------------------------------------------------
module t_clk_flop #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             clk2,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q2,
    output logic [CNT_W-1:0] cnt2
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q2_q;
    logic [CNT_W-1:0] cnt2_q;
    logic [CNT_W-1:0] cnt2_d;

    // clk domain: one-cycle register of a; X on a is carried through as data
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            q_q <= '0;
        end else begin
            q_q <= a;
        end
    end

    // clk2 domain: resample q. Non-blocking updates mean that a clk edge
    // coinciding with a clk2 edge lets q2 see the pre-edge value of q.
`ifdef T_CLK_FLOP_SYNC2_EN
    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk2 or negedge reset_l) begin
        if (!reset_l) begin
            meta_q <= '0;
            q2_q   <= '0;
        end else begin
            meta_q <= q_q;
            q2_q   <= meta_q;
        end
    end
`else
    always_ff @(posedge clk2 or negedge reset_l) begin
        if (!reset_l) begin
            q2_q <= '0;
        end else begin
            q2_q <= q_q;
        end
    end
`endif

    // clk2 domain: free-running counter, natural wrap at 2^CNT_W
    always_comb begin
        cnt2_d = cnt2_q + CNT_W'(1);
    end

    always_ff @(posedge clk2 or negedge reset_l) begin
        if (!reset_l) begin
            cnt2_q <= '0;
        end else begin
            cnt2_q <= cnt2_d;
        end
    end

    assign q    = q_q;
    assign q2   = q2_q;
    assign cnt2 = cnt2_q;

endmodule

// File: tb/tb_t_clk_flop.sv
// ---------------------------------------------------------------------------
// tb_t_clk_flop
//
// This is a directed bench for t_clk_flop.
//
// Clocks: clk has a 40-unit period. clk2 has a 10-unit period (4x clk).
// The phases are chosen so that every clk posedge coincides with a clk2
// posedge.
//
// Two instances share all inputs. Their outputs are compared after every
// clock edge.
// ---------------------------------------------------------------------------
module tb_t_clk_flop;

`ifdef T_CLK_FLOP_SYNC2_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic       clk;
    logic       clk2;
    logic       reset_l;
    logic [7:0] a;
    logic [7:0] q_a;
    logic [7:0] q2_a;
    logic [7:0] cnt2_a;
    logic [7:0] q_b;
    logic [7:0] q2_b;
    logic [7:0] cnt2_b;

    int checks;
    int errors;
    bit twin_en;

    t_clk_flop #(.WIDTH(8), .CNT_W(8)) u_a (
        .clk     (clk),
        .reset_l (reset_l),
        .clk2    (clk2),
        .a       (a),
        .q       (q_a),
        .q2      (q2_a),
        .cnt2    (cnt2_a)
    );

    t_clk_flop #(.WIDTH(8), .CNT_W(8)) u_b (
        .clk     (clk),
        .reset_l (reset_l),
        .clk2    (clk2),
        .a       (a),
        .q       (q_b),
        .q2      (q2_b),
        .cnt2    (cnt2_b)
    );

    // clk posedges fall at 20, 60, 100, ...
    // clk2 posedges fall at 10, 20, 30, ...
    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial clk2 = 1'b1;
    always #5 clk2 = ~clk2;

    // Twin-instance determinism check after every edge of either clock
    always @(posedge clk or posedge clk2) begin
        #1;
        if (twin_en) begin
            checks++;
            if ({q_a, q2_a, cnt2_a} !== {q_b, q2_b, cnt2_b}) begin
                errors++;
                $display("FAIL twin: a=%h/%h/%h b=%h/%h/%h required equal",
                         q_a, q2_a, cnt2_a, q_b, q2_b, cnt2_b);
            end
        end
    end

    task automatic test_reset;
        reset_l = 1'b1;
        a       = 8'h5A;
        #2;
        reset_l = 1'b0;
        #1;
        checks++;
        if ({q_a, q2_a, cnt2_a} !== 24'h0) begin
            errors++;
            $display("FAIL reset_async: q=%h q2=%h cnt2=%h required 0", q_a, q2_a, cnt2_a);
        end
        twin_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({q_a, q2_a, cnt2_a} !== 24'h0) begin
            errors++;
            $display("FAIL reset_hold: q=%h q2=%h cnt2=%h required 0", q_a, q2_a, cnt2_a);
        end
    endtask

    task automatic test_increment;
        logic [7:0] exp_q2;
        @(negedge clk);
        #3;
        reset_l = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = 8'(k);
            @(posedge clk);
            #1;
            exp_q2 = (k == 0) ? 8'h00 : 8'(k - 1);
            checks++;
            if (q_a !== 8'(k)) begin
                errors++;
                $display("FAIL incr_q[%0d]: got %h required %h", k, q_a, 8'(k));
            end
            checks++;
            if (q2_a !== exp_q2) begin
                errors++;
                $display("FAIL incr_q2[%0d]: got %h required %h", k, q2_a, exp_q2);
            end
        end
    endtask

    task automatic test_cnt_wrap;
        logic [7:0] exp_cnt;
        reset_l = 1'b0;
        #1;
        checks++;
        if (cnt2_a !== 8'h00) begin
            errors++;
            $display("FAIL cnt_reset: got %h required 00", cnt2_a);
        end
        @(posedge clk2);
        #3;
        reset_l = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk2);
            #1;
            exp_cnt = 8'(i);
            checks++;
            if (cnt2_a !== exp_cnt) begin
                errors++;
                $display("FAIL cnt_edge[%0d]: got %h required %h", i, cnt2_a, exp_cnt);
            end
        end
    endtask

    task automatic test_q2_latency;
        @(posedge clk);
        #1;
        a = 8'h3C;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk2);
        #1;
        checks++;
        if (q2_a !== 8'h3C) begin
            errors++;
            $display("FAIL lat_pre: q2 got %h required 3c", q2_a);
        end
        a = 8'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'hA5) begin
            errors++;
            $display("FAIL lat_q: got %h required a5", q_a);
        end
        checks++;
        if (q2_a !== 8'h3C) begin
            errors++;
            $display("FAIL lat_q2_edge0: got %h required 3c", q2_a);
        end
        for (int j = 1; j <= SYNC_LAT; j++) begin
            @(posedge clk2);
            #1;
            checks++;
            if (q2_a !== ((j < SYNC_LAT) ? 8'h3C : 8'hA5)) begin
                errors++;
                $display("FAIL lat_q2_edge%0d: got %h required %h", j, q2_a,
                         (j < SYNC_LAT) ? 8'h3C : 8'hA5);
            end
        end
    endtask

    task automatic test_coincident;
        a = 8'h02;
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'h02) begin
            errors++;
            $display("FAIL coin_q2: got %h required 02", q_a);
        end
        a = 8'h03;
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'h03) begin
            errors++;
            $display("FAIL coin_q3: got %h required 03", q_a);
        end
        checks++;
        if (q2_a !== 8'h02) begin
            errors++;
            $display("FAIL coin_q2_capture: got %h required 02", q2_a);
        end
    endtask

    task automatic test_midstream_reset;
        a = 8'h07;
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'h07) begin
            errors++;
            $display("FAIL mid_q7: got %h required 07", q_a);
        end
        repeat (3) @(posedge clk2);
        #3;
        reset_l = 1'b0;
        #1;
        checks++;
        if ({q_a, q2_a, cnt2_a} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: q=%h q2=%h cnt2=%h required 0", q_a, q2_a, cnt2_a);
        end
        a = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q_a, q2_a, cnt2_a} !== 24'h0) begin
            errors++;
            $display("FAIL mid_hold: q=%h q2=%h cnt2=%h required 0", q_a, q2_a, cnt2_a);
        end
        @(negedge clk);
        #3;
        reset_l = 1'b1;
        a = 8'h09;
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'h09) begin
            errors++;
            $display("FAIL resume_q: got %h required 09", q_a);
        end
        checks++;
        if (q2_a !== 8'h00) begin
            errors++;
            $display("FAIL resume_q2: got %h required 00", q2_a);
        end
        checks++;
        if (cnt2_a !== 8'h02) begin
            errors++;
            $display("FAIL resume_cnt2: got %h required 02", cnt2_a);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        twin_en = 1'b0;
        test_reset();
        test_increment();
        test_cnt_wrap();
        test_q2_latency();
        test_coincident();
        test_midstream_reset();
        repeat (2) @(posedge clk);
        #2;
        twin_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
